// File: rtl/alu_issue_stage_if.sv
// Handshake and operand bundle between the ALU issue stage and its neighbours.
// The stage uses the slave view; the master view drives instructions and consumes operands.
interface alu_issue_stage_if;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        instr;
    logic [31:0]        rs_data;
    logic [31:0]        rt_data;
    logic               fwd_valid;
    logic [4:0]         fwd_rd;
    logic [31:0]        fwd_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] input1;
    logic signed [31:0] input2;
    logic [3:0]         aluControlOut;
    logic [4:0]         shumt;
    logic [4:0]         out_rd;
    logic               out_illegal;

    modport master (
        output flush, in_valid, instr, rs_data, rt_data,
        output fwd_valid, fwd_rd, fwd_data, out_ready,
        input  in_ready, out_valid, input1, input2, aluControlOut,
        input  shumt, out_rd, out_illegal
    );

    modport slave (
        input  flush, in_valid, instr, rs_data, rt_data,
        input  fwd_valid, fwd_rd, fwd_data, out_ready,
        output in_ready, out_valid, input1, input2, aluControlOut,
        output shumt, out_rd, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// MIPS decode/issue stage: decodes one instruction per cycle into ALU operands and
// holds up to two entries in a skid FIFO whose register operands track forwarded results.
module alu_issue_stage #(
    parameter int unsigned DEPTH = 2
) (
    input logic              clk,
    input logic              reset_n,
    alu_issue_stage_if.slave bus
);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_SLL = 4'd4,
        OP_SRL = 4'd5,
        OP_SRA = 4'd6,
        OP_SGT = 4'd7,
        OP_SLT = 4'd8
    } alu_op_e;

    typedef struct packed {
        alu_op_e     op;
        logic        a_reg;
        logic [4:0]  a_idx;
        logic [31:0] a_val;
        logic        b_reg;
        logic [4:0]  b_idx;
        logic [31:0] b_val;
        logic [4:0]  shumt;
        logic [4:0]  rd;
        logic        illegal;
    } entry_t;

    localparam logic [1:0] FULL = 2'(DEPTH);

    entry_t     mem_q [DEPTH];
    entry_t     mem_d [DEPTH];
    entry_t     hold_q, hold_d;
    logic [1:0] count_q, count_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       wr_ptr_q, wr_ptr_d;

    entry_t     dec, cap, head, shown;
    logic       illegal, shift, push, pop;
    logic [5:0] opcode, funct;
    logic [4:0] rs_idx, rt_idx;

    // Index 0 always reads zero; forwarding needs idx != 0, so fwd_rd == 0 never matches.
    function automatic logic [31:0] resolve(input logic is_reg, input logic [4:0] idx,
                                            input logic [31:0] val, input logic fv,
                                            input logic [4:0] frd, input logic [31:0] fdata);
        if (!is_reg)
            return val;
        if (idx == 5'd0)
            return '0;
        if (fv && (frd == idx))
            return fdata;
        return val;
    endfunction

    function automatic entry_t patch(input entry_t e, input logic fv,
                                     input logic [4:0] frd, input logic [31:0] fdata);
        entry_t r;
        r       = e;
        r.a_val = resolve(e.a_reg, e.a_idx, e.a_val, fv, frd, fdata);
        r.b_val = resolve(e.b_reg, e.b_idx, e.b_val, fv, frd, fdata);
        return r;
    endfunction

    assign opcode = bus.instr[31:26];
    assign funct  = bus.instr[5:0];
    assign rs_idx = bus.instr[25:21];
    assign rt_idx = bus.instr[20:16];

    always_comb begin
        dec     = '0;
        illegal = 1'b0;
        shift   = 1'b0;
        case (opcode)
            6'h00: begin
                dec.a_reg = 1'b1;
                dec.a_idx = rs_idx;
                dec.a_val = bus.rs_data;
                dec.b_reg = 1'b1;
                dec.b_idx = rt_idx;
                dec.b_val = bus.rt_data;
                dec.rd    = bus.instr[15:11];
                case (funct)
                    6'h20, 6'h21: dec.op = OP_ADD;
                    6'h22, 6'h23: dec.op = OP_SUB;
                    6'h24:        dec.op = OP_AND;
                    6'h25:        dec.op = OP_OR;
                    6'h2A:        dec.op = OP_SLT;
                    6'h00: begin dec.op = OP_SLL; shift = 1'b1; end
                    6'h02: begin dec.op = OP_SRL; shift = 1'b1; end
                    6'h03: begin dec.op = OP_SRA; shift = 1'b1; end
                    default:      illegal = 1'b1;
                endcase
                // Shifts take rt as operand A and carry no register operand B.
                if (shift) begin
                    dec.a_idx = rt_idx;
                    dec.a_val = bus.rt_data;
                    dec.b_reg = 1'b0;
                    dec.b_idx = '0;
                    dec.b_val = '0;
                    dec.shumt = bus.instr[10:6];
                end
            end
            6'h04: begin
                dec.op    = OP_SUB;
                dec.a_reg = 1'b1;
                dec.a_idx = rs_idx;
                dec.a_val = bus.rs_data;
                dec.b_reg = 1'b1;
                dec.b_idx = rt_idx;
                dec.b_val = bus.rt_data;
            end
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B: begin
                dec.a_reg = 1'b1;
                dec.a_idx = rs_idx;
                dec.a_val = bus.rs_data;
                dec.rd    = rt_idx;
                dec.b_val = {{16{bus.instr[15]}}, bus.instr[15:0]};
                case (opcode)
                    6'h0A: dec.op = OP_SLT;
                    6'h0C: begin dec.op = OP_AND; dec.b_val = {16'h0000, bus.instr[15:0]}; end
                    6'h0D: begin dec.op = OP_OR;  dec.b_val = {16'h0000, bus.instr[15:0]}; end
                    6'h2B: dec.rd = '0;
                    default: dec.op = OP_ADD;
                endcase
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

    assign cap  = patch(dec, bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
    assign head = mem_q[rd_ptr_q];

    assign bus.in_ready  = (count_q < FULL);
    assign bus.out_valid = (count_q != 2'd0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // Once empty, outputs show the last head seen rather than whatever stale slot rd_ptr lands on.
    assign shown             = bus.out_valid ? head : hold_q;
    assign bus.input1        = shown.a_val;
    assign bus.input2        = shown.b_val;
    assign bus.aluControlOut = shown.op;
    assign bus.shumt         = shown.shumt;
    assign bus.out_rd        = shown.rd;
    assign bus.out_illegal   = shown.illegal;

    always_comb begin
        mem_d    = mem_q;
        hold_d   = hold_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (bus.out_valid)
            hold_d = head;
        if (bus.flush) begin
            count_d  = '0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            mem_d[0] = patch(mem_q[0], bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
            mem_d[1] = patch(mem_q[1], bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
            if (push) begin
                mem_d[wr_ptr_q] = cap;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop)
                rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '{default: '0};
            hold_q   <= '0;
            count_q  <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            hold_q   <= hold_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

endmodule
